// File: rtl/mont_pkg.sv
// mont_pkg: shared constants for the Montgomery multiplier controller.
// Holds the default operand width, adder width, the controller's state
// encoding, and the constant-time latency figure.
package mont_pkg;

    localparam int N_DEF     = 512;
    localparam int ADD_W_DEF = N_DEF + 2;
    localparam int CYCLES_CT = 4 * N_DEF + 3;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE     = 3'd0;
    localparam state_t S_ADD_B    = 3'd1;
    localparam state_t S_WAIT_B   = 3'd2;
    localparam state_t S_ADD_M    = 3'd3;
    localparam state_t S_WAIT_M   = 3'd4;
    localparam state_t S_SUB      = 3'd5;
    localparam state_t S_WAIT_SUB = 3'd6;
    localparam state_t S_FIN      = 3'd7;

    // Constant-time latency for an arbitrary operand width.
    function automatic int cyclesCt(input int n);
        return 4 * n + 3;
    endfunction

endpackage

// File: rtl/mont_opnd_shreg.sv
// mont_opnd_shreg: scan register for the multiplier operand a.
// Holds the not-yet-consumed upper bits of a (a[N-1:1] at load time); bit 0
// of the register is always the a-bit of the next loop iteration. Bit a[0]
// is consumed directly by the controller at load time. Also counts
// iterations and flags the final one.
module mont_opnd_shreg
    import mont_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         i_load,
    input  logic [N-2:0] i_load_bits,
    input  logic         i_shift,
    output logic         o_next_bit,
    output logic         o_last
);

    localparam int CW = (N > 2) ? $clog2(N) : 1;

    logic [N-2:0]  r_bits;
    logic [CW-1:0] r_cnt;

    // Load a fresh operand on accept, otherwise drop one bit per finished iteration.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_bits <= '0;
            r_cnt  <= '0;
        end else if (i_load) begin
            r_bits <= i_load_bits;
            r_cnt  <= '0;
        end else if (i_shift) begin
            r_bits <= r_bits >> 1;
            r_cnt  <= r_cnt + CW'(1);
        end
    end

    assign o_next_bit = r_bits[0];
    assign o_last     = (r_cnt == CW'(N - 1));

endmodule

// File: rtl/mont_mul_ctrl.sv
// mont_mul_ctrl: bit-serial radix-2 Montgomery multiplier controller.
// Computes result = a*b*2^-N mod m by sequencing an external add/subtract/
// shift datapath through a start/done handshake; owns accumulator C and the
// loop FSM, with no arithmetic of its own beyond operand muxes.
// Build option MONT_SKIP_ZERO_EN: skip the b-addition for zero bits of a
// (faster, but timing then depends on a). Undefined = constant-time.
module mont_mul_ctrl
    import mont_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int ADD_W = N + 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [N-1:0]     in_a,
    input  logic [N-1:0]     in_b,
    input  logic [N-1:0]     in_m,
    output logic [N-1:0]     result,
    output logic             done,
    output logic             busy,
    output logic             add_start,
    output logic             add_subtract,
    output logic             add_shift,
    output logic [ADD_W-1:0] add_in_a,
    output logic [ADD_W-1:0] add_in_b,
    input  logic [ADD_W:0]   add_result,
    input  logic             add_done
);

`ifdef MONT_SKIP_ZERO_EN
    localparam bit SKIP_ZERO = 1'b1;
`else
    localparam bit SKIP_ZERO = 1'b0;
`endif

    state_t           r_state;
    logic [N-1:0]     r_b;
    logic [N-1:0]     r_m;
    logic [N-1:0]     r_result;
    logic [ADD_W-1:0] r_c;
    logic [ADD_W-1:0] r_add_in_b;
    logic             r_done;
    logic             r_busy;
    logic             r_add_start;
    logic             r_add_subtract;
    logic             r_add_shift;

    logic             w_load;
    logic             w_shift;
    logic             w_next_bit;
    logic             w_last;
    logic [ADD_W-1:0] w_sum;
    logic [ADD_W-1:0] w_b_ext;
    logic [ADD_W-1:0] w_m_ext;

    assign w_sum   = add_result[ADD_W-1:0];
    assign w_load  = (r_state == S_IDLE) && start;
    assign w_shift = (r_state == S_WAIT_M) && add_done;
    assign w_b_ext = ADD_W'(r_b);
    assign w_m_ext = ADD_W'(r_m);

    mont_opnd_shreg #(
        .N(N)
    ) u_shreg (
        .clk         (clk),
        .resetn      (resetn),
        .i_load      (w_load),
        .i_load_bits (in_a[N-1:1]),
        .i_shift     (w_shift),
        .o_next_bit  (w_next_bit),
        .o_last      (w_last)
    );

    // Loop FSM: every adder request is registered on the edge that enters its
    // issue state, so operands are stable for the whole request/done window.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state        <= S_IDLE;
            r_b            <= '0;
            r_m            <= '0;
            r_result       <= '0;
            r_c            <= '0;
            r_add_in_b     <= '0;
            r_done         <= 1'b0;
            r_busy         <= 1'b0;
            r_add_start    <= 1'b0;
            r_add_subtract <= 1'b0;
            r_add_shift    <= 1'b0;
        end else begin
            r_add_start <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_b            <= in_b;
                        r_m            <= in_m;
                        r_c            <= '0;
                        r_busy         <= 1'b1;
                        r_add_start    <= 1'b1;
                        r_add_subtract <= 1'b0;
                        if (SKIP_ZERO && !in_a[0]) begin
                            r_state     <= S_ADD_M;
                            r_add_shift <= 1'b1;
                            r_add_in_b  <= '0;
                        end else begin
                            r_state     <= S_ADD_B;
                            r_add_shift <= 1'b0;
                            r_add_in_b  <= in_a[0] ? ADD_W'(in_b) : '0;
                        end
                    end
                end
                S_ADD_B: r_state <= S_WAIT_B;
                S_WAIT_B: begin
                    if (add_done) begin
                        r_c         <= w_sum;
                        r_state     <= S_ADD_M;
                        r_add_start <= 1'b1;
                        r_add_shift <= 1'b1;
                        r_add_in_b  <= w_sum[0] ? w_m_ext : '0;
                    end
                end
                S_ADD_M: r_state <= S_WAIT_M;
                S_WAIT_M: begin
                    if (add_done) begin
                        r_c         <= w_sum;
                        r_add_start <= 1'b1;
                        if (w_last) begin
                            r_state        <= S_SUB;
                            r_add_subtract <= 1'b1;
                            r_add_shift    <= 1'b0;
                            r_add_in_b     <= w_m_ext;
                        end else if (SKIP_ZERO && !w_next_bit) begin
                            r_state     <= S_ADD_M;
                            r_add_shift <= 1'b1;
                            r_add_in_b  <= w_sum[0] ? w_m_ext : '0;
                        end else begin
                            r_state     <= S_ADD_B;
                            r_add_shift <= 1'b0;
                            r_add_in_b  <= w_next_bit ? w_b_ext : '0;
                        end
                    end
                end
                S_SUB: r_state <= S_WAIT_SUB;
                S_WAIT_SUB: begin
                    if (add_done) begin
                        r_result <= add_result[ADD_W] ? r_c[N-1:0] : add_result[N-1:0];
                        r_done   <= 1'b1;
                        r_state  <= S_FIN;
                    end
                end
                S_FIN: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign result       = r_result;
    assign done         = r_done;
    assign busy         = r_busy;
    assign add_start    = r_add_start;
    assign add_subtract = r_add_subtract;
    assign add_shift    = r_add_shift;
    assign add_in_a     = r_c;
    assign add_in_b     = r_add_in_b;

endmodule

// File: tb/tb_mont_mul_ctrl.sv
// tb_mont_mul_ctrl: self-checking bench for mont_mul_ctrl at N=8.
// A behavioural adder answers the controller's requests (optionally stalling
// 0-3 cycles); a reference model predicts busy/done/result every cycle from
// plain modular arithmetic. Honours MONT_SKIP_ZERO_EN for expected latency.
module tb_mont_mul_ctrl;

    localparam int N     = 8;
    localparam int ADD_W = N + 2;

`ifdef MONT_SKIP_ZERO_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             resetn;
    logic             start;
    logic [N-1:0]     inA, inB, inM;
    logic [N-1:0]     result;
    logic             done, busy;
    logic             addStart, addSubtract, addShift;
    logic [ADD_W-1:0] addInA, addInB;
    logic [ADD_W:0]   addResult = '0;
    logic             addDone = 1'b0;

    int vecCount, missCount;

    // behavioural adder state
    int             stallMax = 0;
    int             stallTotal = 0;
    int             addDelay = 0;
    bit             addPend = 1'b0;
    bit             lastSubNonNeg = 1'b0;
    logic [ADD_W:0] addVal = '0;

    // reference model state
    bit         mBusy = 1'b0;
    int         cnt = 0;
    int         mLat = 0;
    logic [7:0] pendResult = '0;
    logic [7:0] expResult = '0;
    bit         expBusy = 1'b0;
    bit         expDone = 1'b0;

    mont_mul_ctrl #(.N(N), .ADD_W(ADD_W)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .start        (start),
        .in_a         (inA),
        .in_b         (inB),
        .in_m         (inM),
        .result       (result),
        .done         (done),
        .busy         (busy),
        .add_start    (addStart),
        .add_subtract (addSubtract),
        .add_shift    (addShift),
        .add_in_a     (addInA),
        .add_in_b     (addInB),
        .add_result   (addResult),
        .add_done     (addDone)
    );

    always #5 clk = ~clk;

    // a*b*2^-N mod m, found as the unique r < m with r*2^N == a*b (mod m)
    function automatic logic [7:0] montRef(input int a, input int b, input int m);
        int t = (a * b) % m;
        for (int r = 0; r < m; r++)
            if (((r << N) % m) == t) return r[7:0];
        return 8'h00;
    endfunction

    // cycles from accept to the done cycle inclusive, with no adder stalls
    function automatic int latencyOf(input logic [7:0] a);
        int z = N - $countones(a);
        return SKIP ? (4 * N + 3 - 2 * z) : (4 * N + 3);
    endfunction

    // Adder and reference model advance together on every rising edge.
    initial forever begin
        @(posedge clk);
        if (!resetn) begin
            addPend    = 1'b0;
            addDone   <= 1'b0;
            addResult <= '0;
            stallTotal = 0;
            mBusy      = 1'b0;
            cnt        = 0;
            expResult  = 8'h00;
        end else begin
            addDone <= 1'b0;
            if (addPend) begin
                if (addDelay == 0) begin
                    addDone   <= 1'b1;
                    addResult <= addVal;
                    addPend    = 1'b0;
                end else begin
                    addDelay--;
                end
            end
            if (addStart) begin
                int stall;
                if (addSubtract) begin
                    addVal = {1'b0, addInA} - {1'b0, addInB};
                    lastSubNonNeg = ~addVal[ADD_W];
                end else begin
                    addVal = {1'b0, addInA} + {1'b0, addInB};
                    if (addShift) addVal = addVal >> 1;
                end
                stall = (stallMax == 0) ? 0 : int'($urandom_range(0, stallMax));
                stallTotal += stall;
                if (stall == 0) begin
                    addDone   <= 1'b1;
                    addResult <= addVal;
                end else begin
                    addPend  = 1'b1;
                    addDelay = stall - 1;
                end
            end
            if (mBusy) begin
                if (cnt == mLat + stallTotal) mBusy = 1'b0;
                else cnt++;
            end else if (start) begin
                mBusy      = 1'b1;
                cnt        = 1;
                mLat       = latencyOf(inA);
                pendResult = montRef(inA, inB, inM);
                stallTotal = 0;
            end
        end
        expBusy = mBusy;
        expDone = mBusy && (cnt == mLat + stallTotal);
        if (expDone) expResult = pendResult;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecCount++;
        if (act !== exp) begin
            missCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // one clock of progress, comparing the DUT against the model mid-cycle
    task automatic tick();
        @(negedge clk);
        checkOutput("cycDone", 32'(done), 32'(expDone));
        checkOutput("cycBusy", 32'(busy), 32'(expBusy));
        checkOutput("cycResult", 32'(result), 32'(expResult));
    endtask

    // one operation; returns cycles to done (-1 if none) and number of dones seen
    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic [7:0] m,
                                 input bit holdStart, output int lat, output int nDone);
        inA   = a;
        inB   = b;
        inM   = m;
        start = 1'b1;
        lat   = -1;
        nDone = 0;
        for (int k = 1; k <= 400; k++) begin
            tick();
            if (!holdStart) start = 1'b0;
            if (done === 1'b1) begin
                nDone++;
                if (lat < 0) lat = k;
                start = 1'b0;
            end
            if (lat >= 0 && k >= lat + 4) break;
        end
        start = 1'b0;
    endtask

    logic [7:0] dA   [4] = '{8'h01, 8'h0F, 8'hFE, 8'h00};
    logic [7:0] dB   [4] = '{8'h01, 8'h37, 8'hFE, 8'h55};
    logic [7:0] dM   [4] = '{8'hF1, 8'hF1, 8'hFF, 8'hF1};
    logic [7:0] dRes [4] = '{8'hE1, 8'h37, 8'h01, 8'h00};
`ifdef MONT_SKIP_ZERO_EN
    int dLat [4] = '{21, 27, 33, 19};
`else
    int dLat [4] = '{35, 35, 35, 35};
`endif

    initial begin
        int lat, nDone, doneSeen;
        logic [7:0] rm, ra, rb;
        vecCount  = 0;
        missCount = 0;
        resetn = 1'b0;
        start  = 1'b0;
        inA    = '0;
        inB    = '0;
        inM    = '0;
        repeat (2) @(negedge clk);

        checkOutput("pinModelE1", 32'(montRef(8'h01, 8'h01, 8'hF1)), 32'hE1);
        checkOutput("pinModel37", 32'(montRef(8'h0F, 8'h37, 8'hF1)), 32'h37);
        checkOutput("pinModel01", 32'(montRef(8'hFE, 8'hFE, 8'hFF)), 32'h01);
        checkOutput("pinModel56", 32'(montRef(8'h05, 8'h11, 8'hF1)), 32'd86);

        checkOutput("rstResult", 32'(result), 0);
        checkOutput("rstDone", 32'(done), 0);
        checkOutput("rstBusy", 32'(busy), 0);
        checkOutput("rstAddStart", 32'(addStart), 0);
        checkOutput("rstAddSub", 32'(addSubtract), 0);
        checkOutput("rstAddShift", 32'(addShift), 0);
        checkOutput("rstAddInA", 32'(addInA), 0);
        checkOutput("rstAddInB", 32'(addInB), 0);
        resetn = 1'b1;
        tick();

        for (int i = 0; i < 4; i++) begin
            applyStimulus(dA[i], dB[i], dM[i], 1'b0, lat, nDone);
            checkOutput("dirResult", 32'(result), 32'(dRes[i]));
            checkOutput("dirLatency", lat, dLat[i]);
            checkOutput("dirDoneCount", nDone, 1);
            if (dM[i] == 8'hFF) begin
                checkOutput("subPathTaken", 32'(lastSubNonNeg), 1);
                checkOutput("resultBelowM", 32'(result < dM[i]), 1);
            end
        end

        applyStimulus(8'h05, 8'h11, 8'hF1, 1'b1, lat, nDone);
        checkOutput("holdDoneCount", nDone, 1);
        checkOutput("holdResult", 32'(result), 32'd86);

        inA   = 8'h0F;
        inB   = 8'h37;
        inM   = 8'hF1;
        start = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            start = 1'b0;
        end
        resetn = 1'b0;
        tick();
        checkOutput("abortBusy", 32'(busy), 0);
        checkOutput("abortResult", 32'(result), 0);
        resetn = 1'b1;
        doneSeen = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (done === 1'b1) doneSeen++;
        end
        checkOutput("abortNoDone", doneSeen, 0);
        applyStimulus(8'h0F, 8'h37, 8'hF1, 1'b0, lat, nDone);
        checkOutput("postAbortResult", 32'(result), 32'h37);
        checkOutput("postAbortDone", nDone, 1);

        stallMax = 3;
        for (int i = 0; i < 20; i++) begin
            rm = 8'($urandom_range(3, 255)) | 8'h01;
            ra = 8'($urandom_range(0, int'(rm) - 1));
            rb = 8'($urandom_range(0, int'(rm) - 1));
            applyStimulus(ra, rb, rm, 1'b0, lat, nDone);
            checkOutput("rndResult", 32'(result), 32'(montRef(ra, rb, rm)));
            checkOutput("rndLatency", lat, latencyOf(ra) + stallTotal);
            checkOutput("rndDoneCount", nDone, 1);
        end
        stallMax = 0;

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
